commit_collector: RTL and testbench

Gathers completed-instruction results from the execute units and writes them into the ROB completion ports. Each execute unit presents an `execute_to_commit_bus_t` with a valid/allowin handshake. The collector buffers each source in a 2-entry FIFO and grants up to `WB_PORTS` heads per cycle in round-robin order. It sits between the execute stage (ALU, MDU, LSU, branch units) and the ROB, and drives each unit's `cs_allowin`.

---
 rtl/commit_collector_pkg.sv | 34 +++
 rtl/commit_collector_if.sv | 28 ++
 rtl/commit_collector_wb_skid_fifo.sv | 55 +++++
 rtl/commit_collector.sv | 92 +++++++++
 tb/tb_commit_collector.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_collector_pkg.sv
// commit_collector_pkg: shared types and defaults for the commit collector.
// Holds the execute-to-commit result bus, the exception sub-record and the
// default source/port counts used by the collector and its interface.
package commit_collector_pkg;

    localparam int COMMIT_N_SRC    = 4;
    localparam int COMMIT_WB_PORTS = 2;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } exccode_e;

    typedef struct packed {
        logic        ex;
        exccode_e    exccode;
        logic [31:0] badvaddr;
    } exception_t;

    typedef struct packed {
        logic [5:0]  rob_entry_num;
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        dest_we;
        exception_t  exception;
    } execute_to_commit_bus_t;

endpackage

// File: rtl/commit_collector_if.sv
// commit_collector_if: execute-side handshake and ROB completion ports.
// ex_valid/ex_bus/cs_allowin form the per-source handshake; rob_wb_valid and
// rob_wb_bus are the completion write ports. The collector uses the slave
// modport, the execute/ROB environment uses the master modport.
interface commit_collector_if
    import commit_collector_pkg::*;
#(
    parameter int N_SRC    = COMMIT_N_SRC,
    parameter int WB_PORTS = COMMIT_WB_PORTS
) ();

    logic [N_SRC-1:0]       ex_valid;
    execute_to_commit_bus_t ex_bus [N_SRC];
    logic [N_SRC-1:0]       cs_allowin;
    logic [WB_PORTS-1:0]    rob_wb_valid;
    execute_to_commit_bus_t rob_wb_bus [WB_PORTS];

    modport master (
        output ex_valid, ex_bus,
        input  cs_allowin, rob_wb_valid, rob_wb_bus
    );

    modport slave (
        input  ex_valid, ex_bus,
        output cs_allowin, rob_wb_valid, rob_wb_bus
    );

endinterface

// File: rtl/commit_collector_wb_skid_fifo.sv
// wb_skid_fifo: 2-entry result FIFO for one execute source.
// Ports: clk, resetn (async active-low), i_flush (sync clear), i_push/i_data
// (enqueue), i_pop (dequeue), o_head/o_head_valid (current head), o_full
// (both entries occupied, drives the source's allowin low).
module wb_skid_fifo
    import commit_collector_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  execute_to_commit_bus_t i_data,
    output execute_to_commit_bus_t o_head,
    output logic                   o_head_valid,
    output logic                   o_full
);

    execute_to_commit_bus_t r_mem [2];
    logic                   r_wp;
    logic                   r_rp;
    logic [1:0]             r_cnt;
    logic                   w_push;
    logic                   w_pop;

    // Self-protecting: never overwrite a full FIFO or pop an empty one.
    assign w_push       = i_push & ~o_full;
    assign w_pop        = i_pop & o_head_valid;
    assign o_head       = r_mem[r_rp];
    assign o_head_valid = r_cnt != 2'd0;
    assign o_full       = r_cnt == 2'd2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else if (i_flush) begin
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/commit_collector.sv
// commit_collector: buffers execute-unit results and writes up to WB_PORTS
// of them per cycle into the ROB, round-robin across sources.
// Ports: clk, resetn (async active-low), flush (sync, drops everything),
// bus (slave modport): ex_valid/ex_bus in, cs_allowin out per source;
// rob_wb_valid/rob_wb_bus out per completion port.
module commit_collector
    import commit_collector_pkg::*;
#(
    parameter int N_SRC    = COMMIT_N_SRC,
    parameter int WB_PORTS = COMMIT_WB_PORTS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    commit_collector_if.slave bus
);

    localparam int          PW = $clog2(N_SRC);
    localparam logic [PW:0] NS = (PW+1)'(N_SRC);

    logic [N_SRC-1:0]       w_push;
    logic [N_SRC-1:0]       w_pop;
    logic [N_SRC-1:0]       w_head_valid;
    logic [N_SRC-1:0]       w_full;
    logic [N_SRC-1:0]       w_taken;
    execute_to_commit_bus_t w_head [N_SRC];
    logic [PW-1:0]          r_rr_ptr;
    logic [PW-1:0]          w_ptr_nxt;
    logic [WB_PORTS-1:0]    w_gnt_vld;
    logic [PW-1:0]          w_gnt_idx [WB_PORTS];

    // allowin comes straight from the FIFO count register, so a full FIFO
    // granted this cycle still refuses input until the next cycle.
    assign bus.cs_allowin   = ~w_full;
    assign w_push           = bus.ex_valid & ~w_full & {N_SRC{~flush}};
    assign w_pop            = w_taken & {N_SRC{~flush}};
    assign bus.rob_wb_valid = w_gnt_vld & {WB_PORTS{~flush}};

    // Each port takes the first non-empty source, scanning from r_rr_ptr,
    // that an earlier port has not already taken. The pointer follows the
    // last port that received a grant.
    always_comb begin
        logic [PW:0]   v_sum;
        logic [PW-1:0] v_idx;
        v_sum     = '0;
        v_idx     = '0;
        w_taken   = '0;
        w_gnt_vld = '0;
        w_ptr_nxt = r_rr_ptr;
        for (int p = 0; p < WB_PORTS; p++)
            w_gnt_idx[p] = '0;
        for (int p = 0; p < WB_PORTS; p++)
            for (int k = 0; k < N_SRC; k++) begin
                v_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
                v_idx = PW'(v_sum >= NS ? v_sum - NS : v_sum);
                if (!w_gnt_vld[p] && w_head_valid[v_idx] && !w_taken[v_idx]) begin
                    w_gnt_vld[p]   = 1'b1;
                    w_gnt_idx[p]   = v_idx;
                    w_taken[v_idx] = 1'b1;
                    w_ptr_nxt      = (32'(v_idx) == N_SRC - 1) ? '0 : v_idx + 1'b1;
                end
            end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_rr_ptr <= '0;
        else if (flush)
            r_rr_ptr <= '0;
        else
            r_rr_ptr <= w_ptr_nxt;
    end

    for (genvar s = 0; s < N_SRC; s++) begin : g_src
        wb_skid_fifo u_fifo (
            .clk          (clk),
            .resetn       (resetn),
            .i_flush      (flush),
            .i_push       (w_push[s]),
            .i_pop        (w_pop[s]),
            .i_data       (bus.ex_bus[s]),
            .o_head       (w_head[s]),
            .o_head_valid (w_head_valid[s]),
            .o_full       (w_full[s])
        );
    end

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_port
        assign bus.rob_wb_bus[p] = w_gnt_vld[p] ? w_head[w_gnt_idx[p]] : '0;
    end

endmodule

// File: tb/tb_commit_collector.sv
// tb_commit_collector: directed and random stimulus checked against a
// queue-based reference model of the collector.
module tb_commit_collector;
    import commit_collector_pkg::*;

    localparam int N = 4;
    localparam int W = 2;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    commit_collector_if #(.N_SRC(N), .WB_PORTS(W)) bus ();

    commit_collector #(.N_SRC(N), .WB_PORTS(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus.slave)
    );

    execute_to_commit_bus_t q [N][$];
    int ptr = 0;
    int total = 0;
    int bad = 0;
    string tag = "init";
    logic [N-1:0] acc = '0;
    int cnt [N];

    function automatic execute_to_commit_bus_t mk(int rob, bit exc);
        execute_to_commit_bus_t b;
        b.rob_entry_num      = 6'(rob);
        b.pc                 = $urandom;
        b.result             = $urandom;
        b.dest               = 5'($urandom);
        b.dest_we            = 1'($urandom);
        b.exception.ex       = exc;
        b.exception.exccode  = exc ? EXC_OV : EXC_INT;
        b.exception.badvaddr = exc ? $urandom : 32'd0;
        return b;
    endfunction

    // Sources granted this cycle, in port order: the first W non-empty
    // queues found walking from ptr around the ring.
    function automatic int predict(output int g [W]);
        int n = 0;
        for (int p = 0; p < W; p++) g[p] = 0;
        for (int k = 0; k < N; k++) begin
            int s = (ptr + k) % N;
            if (q[s].size() > 0 && n < W) begin
                g[n] = s;
                n++;
            end
        end
        return n;
    endfunction

    task automatic chk(string t, logic [63:0] got, logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", t, got, want);
        end
    endtask

    task automatic check();
        int g [W];
        int n;
        logic [N-1:0] ea;
        logic [W-1:0] ev;
        n = predict(g);
        for (int i = 0; i < N; i++) ea[i] = q[i].size() < 2;
        for (int p = 0; p < W; p++) ev[p] = (p < n) && !flush;
        total++;
        assert (bus.cs_allowin === ea) else begin
            bad++;
            $error("FAIL %s allowin got=%b want=%b", tag, bus.cs_allowin, ea);
        end
        total++;
        assert (bus.rob_wb_valid === ev) else begin
            bad++;
            $error("FAIL %s wb_valid got=%b want=%b", tag, bus.rob_wb_valid, ev);
        end
        for (int p = 0; p < W; p++)
            if (ev[p]) begin
                total++;
                assert (bus.rob_wb_bus[p] === q[g[p]][0]) else begin
                    bad++;
                    $error("FAIL %s wb_bus[%0d] got=%h want=%h", tag, p, bus.rob_wb_bus[p], q[g[p]][0]);
                end
            end
    endtask

    task automatic update();
        int g [W];
        int n;
        logic [N-1:0] full;
        n = predict(g);
        acc = '0;
        if (flush) begin
            for (int i = 0; i < N; i++) q[i].delete();
            ptr = 0;
        end else begin
            for (int i = 0; i < N; i++) full[i] = q[i].size() == 2;
            for (int p = 0; p < W; p++)
                if (p < n) void'(q[g[p]].pop_front());
            for (int i = 0; i < N; i++)
                if (bus.ex_valid[i] && !full[i]) begin
                    q[i].push_back(bus.ex_bus[i]);
                    acc[i] = 1'b1;
                end
            if (n > 0) ptr = (g[n-1] + 1) % N;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check();
        @(posedge clk);
        update();
        #1;
    endtask

    initial begin
        bus.ex_valid = '0;
        for (int s = 0; s < N; s++) bus.ex_bus[s] = '0;

        tag = "reset";
        #1 resetn = 1'b0;
        #2;
        chk("reset_allowin", 64'(bus.cs_allowin), 64'hf);
        chk("reset_wb_valid", 64'(bus.rob_wb_valid), 64'h0);
        for (int p = 0; p < W; p++) chk("reset_wb_bus", 64'(|bus.rob_wb_bus[p]), 64'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        tag = "single";
        bus.ex_valid = 4'b0001;
        bus.ex_bus[0] = mk(5, 1'b0);
        step();
        bus.ex_valid = '0;
        #1;
        chk("single_p0_valid", 64'(bus.rob_wb_valid[0]), 64'h1);
        chk("single_p0_rob", 64'(bus.rob_wb_bus[0].rob_entry_num), 64'd5);
        chk("single_p1_valid", 64'(bus.rob_wb_valid[1]), 64'h0);
        step();

        tag = "flush_ptr";
        flush = 1'b1;
        step();
        flush = 1'b0;

        tag = "allsrc";
        for (int s = 0; s < N; s++) begin
            bus.ex_bus[s] = mk(s * 8, 1'b0);
            cnt[s] = 1;
        end
        bus.ex_valid = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            step();
            for (int s = 0; s < N; s++)
                if (acc[s]) begin
                    bus.ex_bus[s] = mk(s * 8 + cnt[s], 1'b0);
                    cnt[s]++;
                end
            #1;
            if (c == 0) begin
                chk("all_c1_valid", 64'(bus.rob_wb_valid), 64'h3);
                chk("all_c1_p0", 64'(bus.rob_wb_bus[0].rob_entry_num), 64'd0);
                chk("all_c1_p1", 64'(bus.rob_wb_bus[1].rob_entry_num), 64'd8);
            end
            if (c == 1) begin
                chk("all_c2_p0", 64'(bus.rob_wb_bus[0].rob_entry_num), 64'd16);
                chk("all_c2_p1", 64'(bus.rob_wb_bus[1].rob_entry_num), 64'd24);
            end
            if (c == 2) chk("backpressure_allowin", 64'(bus.cs_allowin), 64'hc);
        end

        tag = "flush3";
        flush = 1'b1;
        #1;
        chk("flush_wb_valid", 64'(bus.rob_wb_valid), 64'h0);
        step();
        flush = 1'b0;
        bus.ex_valid = '0;
        #1;
        chk("post_flush_allowin", 64'(bus.cs_allowin), 64'hf);
        chk("post_flush_valid", 64'(bus.rob_wb_valid), 64'h0);
        repeat (3) step();

        tag = "exc";
        bus.ex_valid = 4'b0100;
        bus.ex_bus[2] = mk(17, 1'b1);
        step();
        bus.ex_valid = '0;
        #1;
        chk("exc_valid", 64'(bus.rob_wb_valid[0]), 64'h1);
        chk("exc_code", 64'(bus.rob_wb_bus[0].exception.exccode), 64'(EXC_OV));
        chk("exc_ex", 64'(bus.rob_wb_bus[0].exception.ex), 64'h1);
        step();

        tag = "midreset";
        for (int s = 0; s < N; s++) bus.ex_bus[s] = mk(32 + s, 1'b0);
        bus.ex_valid = 4'b1111;
        step();
        step();
        chk("src2_full", 64'(bus.cs_allowin[2]), 64'h0);
        #2 resetn = 1'b0;
        #1;
        chk("inreset_allowin", 64'(bus.cs_allowin), 64'hf);
        chk("inreset_valid", 64'(bus.rob_wb_valid), 64'h0);
        for (int p = 0; p < W; p++) chk("inreset_bus", 64'(|bus.rob_wb_bus[p]), 64'h0);
        for (int i = 0; i < N; i++) q[i].delete();
        ptr = 0;
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int s = 0; s < N; s++) bus.ex_bus[s] = mk(40 + s, 1'b0);
        step();
        bus.ex_valid = '0;
        #1;
        chk("rst_rr_p0", 64'(bus.rob_wb_bus[0].rob_entry_num), 64'd40);
        chk("rst_rr_p1", 64'(bus.rob_wb_bus[1].rob_entry_num), 64'd41);
        repeat (3) step();

        tag = "rand";
        for (int c = 0; c < 400; c++) begin
            bus.ex_valid = 4'($urandom);
            flush = $urandom_range(0, 19) == 0;
            step();
            for (int s = 0; s < N; s++)
                if (acc[s] || $urandom_range(0, 3) == 0)
                    bus.ex_bus[s] = mk(int'($urandom_range(0, 63)), $urandom_range(0, 7) == 0);
        end
        flush = 1'b0;
        bus.ex_valid = '0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
